axi_sram_slave: RTL and testbench

Parametrised AXI slave fronting a single-port, byte-writable, 1-cycle-latency SRAM array. It replaces the fixed 32-bit / 16K-word SRAM wrapper on the bus-side of the interconnect and adds FIXED/INCR/WRAP bursts, SLVERR reporting and read/write fairness. It serves one transaction at a time with full-throughput bursts.

---
 rtl/axi_sram_pkg.sv | 27 ++
 rtl/axi_burst_addr.sv | 55 +++++
 rtl/axi_sram_slave.sv | 195 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// Shared types for the AXI SRAM slave: burst encodings, response codes, FSM states.
// The WRAP-length helper is only referenced when AXI_SRAM_WRAP_BURST_EN is defined.
package axi_sram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WR_RESP
    } state_e;

    // AXI only defines wrapping bursts of 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [31:0] len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address and legality check for one AXI burst beat.
// WRAP addressing exists only when AXI_SRAM_WRAP_BURST_EN is defined; otherwise WRAP is illegal.
module axi_burst_addr
    import axi_sram_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 4,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 16384
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [2:0]        size,
    input  burst_e            burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              burst_ok,
    output logic              beat_ok
);

    localparam int         BYTE_LSB = $clog2(DATA_W / 8);
    localparam logic [2:0] MAX_SIZE = 3'(BYTE_LSB);

    logic [ADDR_W-1:0] incr_addr;

    assign incr_addr = addr + (ADDR_W'(1) << size);
    assign beat_ok   = (addr >> BYTE_LSB) < ADDR_W'(MEM_DEPTH);

`ifdef AXI_SRAM_WRAP_BURST_EN
    logic [ADDR_W-1:0] wrap_mask;

    // Byte mask of the aligned (len+1)<<size block the burst wraps within.
    assign wrap_mask = ((ADDR_W'(len) + 1'b1) << size) - 1'b1;
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        next_addr = addr;
        burst_ok  = (size <= MAX_SIZE);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
`ifdef AXI_SRAM_WRAP_BURST_EN
            BURST_WRAP: begin
                next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                if (!wrap_len_ok(32'(len))) burst_ok = 1'b0;
            end
`endif
            default:     burst_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI slave in front of a single-port byte-writable SRAM; one transaction at a time, one beat per cycle.
// Define AXI_SRAM_WRAP_BURST_EN to support WRAP bursts; otherwise they complete with SLVERR.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 8,
    parameter int LEN_W     = 4,
    parameter int MEM_DEPTH = 16384
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [LEN_W-1:0]      AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_W-1:0]       ARID,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [LEN_W-1:0]      ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        burst_e            burst;
    } req_t;

    state_e            state;
    req_t              req;
    logic [LEN_W:0]    beat_cnt;
    logic              prio_rd;
    logic              wr_err;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] q;

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              burst_ok;
    logic              beat_ok;
    logic              beat_err;
    logic              last_beat;
    logic              over_len;
    logic              ar_fire;
    logic              aw_fire;
    logic              r_fire;
    logic              w_fire;
    logic              mem_we;
    logic              mem_re;
    logic              unused_rd_addr;

    axi_burst_addr #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_burst_addr (
        .addr      (req.addr),
        .len       (req.len),
        .size      (req.size),
        .burst     (req.burst),
        .next_addr (next_addr),
        .burst_ok  (burst_ok),
        .beat_ok   (beat_ok)
    );

    assign beat_err  = !burst_ok || !beat_ok;
    assign last_beat = (beat_cnt == {1'b0, req.len});
    assign over_len  = (beat_cnt > {1'b0, req.len});

    // Readies are gated by ARESETn so nothing is offered while reset is held.
    assign ARREADY = ARESETn && (state == ST_IDLE) && (!AWVALID || prio_rd);
    assign AWREADY = ARESETn && (state == ST_IDLE) && (!ARVALID || !prio_rd);
    assign RVALID  = (state == ST_RD);
    assign WREADY  = (state == ST_WR);
    assign BVALID  = (state == ST_WR_RESP);

    assign ar_fire = ARVALID && ARREADY;
    assign aw_fire = AWVALID && AWREADY;
    assign r_fire  = RVALID && RREADY;
    assign w_fire  = WVALID && WREADY;

    assign RLAST = RVALID && last_beat;
    assign RDATA = (RVALID && !beat_err) ? q : '0;
    assign RRESP = (RVALID && beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign RID   = RVALID ? req.id : '0;
    assign BID   = BVALID ? req.id : '0;
    assign BRESP = (BVALID && wr_err) ? RESP_SLVERR : RESP_OKAY;

    // Reads are only issued on a handshake, so Q holds its beat while the master stalls.
    assign rd_addr        = (state == ST_IDLE) ? ARADDR : next_addr;
    assign rd_idx         = rd_addr[BYTE_LSB +: IDX_W];
    assign wr_idx         = req.addr[BYTE_LSB +: IDX_W];
    assign mem_re         = ar_fire || (r_fire && !last_beat);
    assign mem_we         = w_fire && !over_len && !beat_err;
    assign unused_rd_addr = ^{rd_addr[BYTE_LSB-1:0], rd_addr[ADDR_W-1:BYTE_LSB+IDX_W]};

    // NOTE: the array and its Q register carry no reset; RDATA is masked outside RD instead.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[wr_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
        if (mem_re) q <= mem[rd_idx];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= ST_IDLE;
            req      <= '0;
            beat_cnt <= '0;
            prio_rd  <= 1'b1;
            wr_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_fire) begin
                        req      <= '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE,
                                      burst: burst_e'(ARBURST)};
                        beat_cnt <= '0;
                        if (AWVALID) prio_rd <= !prio_rd;
                        state    <= ST_RD;
                    end else if (aw_fire) begin
                        req      <= '{id: AWID, addr: AWADDR, len: AWLEN, size: AWSIZE,
                                      burst: burst_e'(AWBURST)};
                        beat_cnt <= '0;
                        wr_err   <= 1'b0;
                        if (ARVALID) prio_rd <= !prio_rd;
                        state    <= ST_WR;
                    end
                end
                ST_RD: begin
                    if (RREADY) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            req.addr <= next_addr;
                        end
                    end
                end
                ST_WR: begin
                    if (WVALID) begin
                        // Beats past len, bad beats and an early or late WLAST all poison BRESP.
                        if (over_len || beat_err || (WLAST && !last_beat)) wr_err <= 1'b1;
                        if (WLAST) begin
                            state <= ST_WR_RESP;
                        end else begin
                            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
                            req.addr <= next_addr;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (BREADY) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave at default parameters.
// Expected WRAP results follow AXI_SRAM_WRAP_BURST_EN when the bench is built with it.
module tb_axi_sram_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int         TMO    = 20;

    logic        ACLK;
    logic        ARESETn;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_q [16];
    logic [1:0]  rr_q [16];
    logic        rl_q [16];
    logic [7:0]  rid_q;
    logic [31:0] exp_d [16];
    logic [31:0] st_q [4];
    logic [1:0]  b_resp;
    logic [7:0]  b_id;
    int          r_wait, w_wait, b_wait;

    axi_sram_slave dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .AWID    (AWID),
        .AWADDR  (AWADDR),
        .AWLEN   (AWLEN),
        .AWSIZE  (AWSIZE),
        .AWBURST (AWBURST),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARID    (ARID),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARSIZE  (ARSIZE),
        .ARBURST (ARBURST),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Tasks start and return at posedge+1; outputs are sampled on the falling edge.
    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nb);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < TMO) begin n++; @(negedge ACLK); end
        if (n >= TMO) check("aw_timeout", AWREADY, 1'b1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int b = 0; b < nb; b++) begin
            WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == nb - 1); WVALID = 1'b1;
            n = 0;
            @(negedge ACLK);
            while (!WREADY && n < TMO) begin n++; @(negedge ACLK); end
            if (n >= TMO) check("w_timeout", WREADY, 1'b1);
            if (b == 0) w_wait = n;
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!BVALID && n < TMO) begin n++; @(negedge ACLK); end
        if (n >= TMO) check("b_timeout", BVALID, 1'b1);
        b_wait = n; b_resp = BRESP; b_id = BID;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_cyc);
        int n;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < TMO) begin n++; @(negedge ACLK); end
        if (n >= TMO) check("ar_timeout", ARREADY, 1'b1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == stall_beat) begin
                RREADY = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    @(negedge ACLK);
                    check($sformatf("stall_rvalid%0d", s), RVALID, 1'b1);
                    st_q[s] = RDATA;
                    @(posedge ACLK); #1;
                end
            end
            RREADY = 1'b1;
            n = 0;
            @(negedge ACLK);
            while (!RVALID && n < TMO) begin n++; @(negedge ACLK); end
            if (n >= TMO) check("r_timeout", RVALID, 1'b1);
            if (b == 0) begin r_wait = n; rid_q = RID; end
            rd_q[b] = RDATA; rr_q[b] = RRESP; rl_q[b] = RLAST;
            @(posedge ACLK); #1;
        end
        RREADY = 1'b0;
    endtask

    task automatic check_read(input string tag, input int nb, input logic [1:0] resp,
                              input logic [7:0] id);
        check({tag, "_rid"}, rid_q, id);
        for (int b = 0; b < nb; b++) begin
            check($sformatf("%s_d%0d", tag, b), rd_q[b], exp_d[b]);
            check($sformatf("%s_resp%0d", tag, b), rr_q[b], resp);
            check($sformatf("%s_last%0d", tag, b), rl_q[b], (b == nb - 1));
        end
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;

        // Reset state: every output low while reset is held, readies up right after release.
        #3;
        check("rst_outs", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, BRESP, RRESP,
                           BID, RID, RDATA}, 64'h0);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        #1 check("post_rst_readies", {ARREADY, AWREADY}, 2'b11);

        // INCR write of four words, then read them back.
        for (int b = 0; b < 4; b++) begin wd[b] = 32'h11 * (b + 1); ws[b] = 4'hF; end
        do_write(8'h3C, 32'h100, 4'd3, 3'd2, 2'b01, 4);
        check("incr_wr_bresp", b_resp, OKAY);
        check("incr_wr_bid", b_id, 8'h3C);
        check("incr_wr_wready_lat", w_wait, 0);
        check("incr_wr_bvalid_lat", b_wait, 0);

        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
        do_read(8'h5A, 32'h100, 4'd3, 3'd2, 2'b01, -1, 0);
        check_read("incr_rd", 4, OKAY, 8'h5A);
        check("incr_rd_rvalid_lat", r_wait, 0);
        #1 check("ar_reready", ARREADY, 1'b1);

        // Master stalls three cycles before beat 1: data holds, no beat skipped.
        do_read(8'h5B, 32'h100, 4'd3, 3'd2, 2'b01, 1, 3);
        check_read("stall_rd", 4, OKAY, 8'h5B);
        for (int s = 0; s < 3; s++) check($sformatf("stall_hold%0d", s), st_q[s], 32'h22);

        do_read(8'h77, 32'h108, 4'd3, 3'd2, 2'b10, -1, 0);
`ifdef AXI_SRAM_WRAP_BURST_EN
        exp_d[0] = 32'h33; exp_d[1] = 32'h44; exp_d[2] = 32'h11; exp_d[3] = 32'h22;
        check_read("wrap_rd", 4, OKAY, 8'h77);
`else
        for (int b = 0; b < 4; b++) exp_d[b] = 32'h0;
        check_read("wrap_rd", 4, SLVERR, 8'h77);
`endif

        // Simultaneous AR/AW twice: read wins first, write wins second.
        AWID = 8'h21; AWADDR = 32'h300; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        ARID = 8'h12; ARADDR = 32'h100; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        #1 check("arb1_readies", {ARREADY, AWREADY}, 2'b10);
        do_read(8'h12, 32'h100, 4'd0, 3'd2, 2'b01, -1, 0);
        exp_d[0] = 32'h11;
        check_read("arb1_rd", 1, OKAY, 8'h12);
        ARID = 8'h13; ARADDR = 32'h300; ARVALID = 1'b1;
        #1 check("arb2_readies", {ARREADY, AWREADY}, 2'b01);
        wd[0] = 32'h77; ws[0] = 4'hF;
        do_write(8'h21, 32'h300, 4'd0, 3'd2, 2'b01, 1);
        check("arb2_bresp", b_resp, OKAY);
        check("arb2_bid", b_id, 8'h21);
        do_read(8'h13, 32'h300, 4'd0, 3'd2, 2'b01, -1, 0);
        exp_d[0] = 32'h77;
        check_read("arb3_rd", 1, OKAY, 8'h13);

        // Out-of-range write must not alias onto word 0; partial strobe write.
        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(8'h01, 32'h0, 4'd0, 3'd2, 2'b01, 1);
        check("clr0_bresp", b_resp, OKAY);
        wd[0] = 32'hDEADBEEF;
        do_write(8'h02, 32'h10000, 4'd0, 3'd2, 2'b01, 1);
        check("oor_wr_bresp", b_resp, SLVERR);
        do_read(8'h03, 32'h0, 4'd0, 3'd2, 2'b01, -1, 0);
        exp_d[0] = 32'h0;
        check_read("oor_word0", 1, OKAY, 8'h03);
        do_read(8'h04, 32'h10000, 4'd0, 3'd2, 2'b01, -1, 0);
        check_read("oor_rd", 1, SLVERR, 8'h04);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h3;
        do_write(8'h05, 32'h0, 4'd0, 3'd2, 2'b01, 1);
        check("strb_wr_bresp", b_resp, OKAY);
        do_read(8'h06, 32'h0, 4'd0, 3'd2, 2'b01, -1, 0);
        exp_d[0] = 32'h0000CCDD;
        check_read("strb_rd", 1, OKAY, 8'h06);

        // Extra beat past len is discarded and flagged.
        wd[0] = 32'h55; ws[0] = 4'hF;
        do_write(8'h07, 32'h204, 4'd0, 3'd2, 2'b01, 1);
        check("pre204_bresp", b_resp, OKAY);
        wd[0] = 32'hA1; wd[1] = 32'hB2; ws[1] = 4'hF;
        do_write(8'h08, 32'h200, 4'd0, 3'd2, 2'b01, 2);
        check("extra_beat_bresp", b_resp, SLVERR);
        do_read(8'h09, 32'h200, 4'd1, 3'd2, 2'b01, -1, 0);
        exp_d[0] = 32'hA1; exp_d[1] = 32'h55;
        check_read("extra_beat_rd", 2, OKAY, 8'h09);

        // Reserved burst type and oversized beats.
        do_read(8'h0A, 32'h100, 4'd1, 3'd2, 2'b11, -1, 0);
        exp_d[0] = 32'h0; exp_d[1] = 32'h0;
        check_read("rsvd_rd", 2, SLVERR, 8'h0A);
        wd[0] = 32'h99; ws[0] = 4'hF;
        do_write(8'h0B, 32'h104, 4'd0, 3'd3, 2'b01, 1);
        check("size_wr_bresp", b_resp, SLVERR);

        // Reset in the middle of an 8-beat read.
        ARID = 8'h0C; ARADDR = 32'h100; ARLEN = 4'd7; ARSIZE = 3'd2; ARBURST = 2'b01;
        ARVALID = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        repeat (2) begin @(posedge ACLK); #1; end
        @(negedge ACLK);
        check("mid_rd_beat2", {RVALID, RDATA}, {1'b1, 32'h33});
        ARESETn = 1'b0; RREADY = 1'b0;
        #1 check("mid_rst_outs", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, BRESP, RRESP,
                                  BID, RID, RDATA}, 64'h0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        do_read(8'h0D, 32'h104, 4'd0, 3'd2, 2'b01, -1, 0);
        exp_d[0] = 32'h22;
        check_read("post_rst_rd", 1, OKAY, 8'h0D);
        check("post_rst_rvalid_lat", r_wait, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
